// File: rtl/f_key_quant_pkg.sv
// Shared constants for the key quantiser: key range, the key-to-phase-increment
// table (index = key - 12) and the FSM state encoding.
package f_key_quant_pkg;

    typedef logic [23:0] incr_t;
    typedef logic [6:0]  key_t;

    localparam int   KEY_MIN  = 12;
    localparam int   KEY_MAX  = 119;
    localparam int   N_KEYS   = 108;
    localparam key_t IDX_LAST = 7'(N_KEYS - 1);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SEARCH = 2'd1;
    localparam state_t ST_PICK   = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // round(INCR[69] * 2^((k-69)/12)) with INCR[69] = 167381 (A4); strictly increasing
    localparam incr_t INCR [N_KEYS] = '{
        24'd6220,    24'd6590,    24'd6982,    24'd7397,    24'd7837,    24'd8303,
        24'd8797,    24'd9320,    24'd9874,    24'd10461,   24'd11083,   24'd11742,
        24'd12441,   24'd13180,   24'd13964,   24'd14795,   24'd15674,   24'd16606,
        24'd17594,   24'd18640,   24'd19748,   24'd20923,   24'd22167,   24'd23485,
        24'd24881,   24'd26361,   24'd27928,   24'd29589,   24'd31349,   24'd33213,
        24'd35188,   24'd37280,   24'd39497,   24'd41845,   24'd44333,   24'd46970,
        24'd49763,   24'd52722,   24'd55857,   24'd59178,   24'd62697,   24'd66425,
        24'd70375,   24'd74560,   24'd78993,   24'd83691,   24'd88667,   24'd93939,
        24'd99525,   24'd105443,  24'd111713,  24'd118356,  24'd125394,  24'd132850,
        24'd140750,  24'd149120,  24'd157987,  24'd167381,  24'd177334,  24'd187879,
        24'd199051,  24'd210887,  24'd223427,  24'd236712,  24'd250788,  24'd265701,
        24'd281500,  24'd298239,  24'd315973,  24'd334762,  24'd354668,  24'd375758,
        24'd398101,  24'd421774,  24'd446854,  24'd473425,  24'd501576,  24'd531402,
        24'd563000,  24'd596478,  24'd631947,  24'd669524,  24'd709336,  24'd751515,
        24'd796203,  24'd843547,  24'd893707,  24'd946850,  24'd1003153, 24'd1062803,
        24'd1126001, 24'd1192956, 24'd1263893, 24'd1339048, 24'd1418672, 24'd1503031,
        24'd1592405, 24'd1687095, 24'd1787415, 24'd1893700, 24'd2006305, 24'd2125606,
        24'd2252001, 24'd2385912, 24'd2527786, 24'd2678096, 24'd2837344, 24'd3006061
    };

endpackage

// File: rtl/fkq_incr_rom.sv
// Combinational read of the shared increment table by 7-bit index.
// Indices past the last key read as all-ones so they always compare as "above F".
module fkq_incr_rom
    import f_key_quant_pkg::*;
(
    input  logic [6:0] idx,
    output incr_t      incr
);

    always_comb begin
        incr = '1;
        if (idx < 7'(N_KEYS)) begin
            incr = INCR[idx];
        end
    end

endmodule

// File: rtl/f_key_quant.sv
// Phase increment -> nearest MIDI key by fixed 7-step binary search over INCR.
// FKQ_DELTA_EN builds the signed residual output DELTA; otherwise DELTA is tied to 0.
//
// state  | meaning
// IDLE   | IN_READY high, waiting for F_IN
// SEARCH | 7 bisection steps, lo tracks largest index with INCR <= F
// PICK   | choose lo or lo+1 by linear distance, register results
// DONE   | OUT_VALID high until OUT_READY
module f_key_quant
    import f_key_quant_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [23:0] F_IN,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [6:0]  KEY_OUT,
    output logic        BELOW,
    output logic        ABOVE,
    output logic [24:0] DELTA
);

    state_t      state, state_nxt;
    incr_t       f_reg;
    logic [6:0]  lo, hi;
    logic [2:0]  step;
    logic [7:0]  mid_sum;
    logic [6:0]  mid, rom_a_idx, rom_b_idx, idx_sel;
    incr_t       incr_a, incr_b;
    logic [24:0] d_lo, d_hi;
    logic        below_c, above_c, at_top, pick_hi;

    assign mid_sum   = {1'b0, lo} + {1'b0, hi} + 8'd1;
    assign mid       = 7'(mid_sum >> 1);
    assign at_top    = (lo == IDX_LAST);
    // Port A serves the bisection midpoint, then INCR[lo] during PICK.
    assign rom_a_idx = (state == ST_PICK) ? lo : mid;
    assign rom_b_idx = at_top ? lo : lo + 7'd1;

    fkq_incr_rom u_rom_a (.idx(rom_a_idx), .incr(incr_a));
    fkq_incr_rom u_rom_b (.idx(rom_b_idx), .incr(incr_b));

    assign below_c = (f_reg < INCR[0]);
    assign above_c = (f_reg > INCR[N_KEYS-1]);
    assign d_lo    = {1'b0, f_reg} - {1'b0, incr_a};
    assign d_hi    = {1'b0, incr_b} - {1'b0, f_reg};
    // Strict compare: an exact tie stays on the lower key.
    assign pick_hi = !at_top && !below_c && (d_hi < d_lo);
    assign idx_sel = pick_hi ? rom_b_idx : lo;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (IN_VALID && IN_READY) state_nxt = ST_SEARCH;
            ST_SEARCH: if (step == 3'd6) state_nxt = ST_PICK;
            ST_PICK:   state_nxt = ST_DONE;
            ST_DONE:   if (OUT_READY) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            IN_READY  <= 1'b0;
            OUT_VALID <= 1'b0;
            f_reg     <= '0;
            lo        <= '0;
            hi        <= '0;
            step      <= '0;
            KEY_OUT   <= 7'(KEY_MIN);
            BELOW     <= 1'b0;
            ABOVE     <= 1'b0;
        end else begin
            state     <= state_nxt;
            IN_READY  <= (state_nxt == ST_IDLE);
            OUT_VALID <= (state_nxt == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (IN_VALID && IN_READY) begin
                        f_reg <= F_IN;
                        lo    <= '0;
                        hi    <= IDX_LAST;
                        step  <= '0;
                    end
                end
                ST_SEARCH: begin
                    step <= step + 3'd1;
                    if (incr_a <= f_reg) lo <= mid;
                    else                 hi <= mid - 7'd1;
                end
                ST_PICK: begin
                    KEY_OUT <= idx_sel + 7'(KEY_MIN);
                    BELOW   <= below_c;
                    ABOVE   <= above_c;
                end
                default: ;
            endcase
        end
    end

`ifdef FKQ_DELTA_EN
    incr_t       incr_sel;
    logic [24:0] delta_c;

    assign incr_sel = pick_hi ? incr_b : incr_a;
    assign delta_c  = {1'b0, f_reg} - {1'b0, incr_sel};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)              DELTA <= '0;
        else if (state == ST_PICK) DELTA <= delta_c;
    end
`else
    assign DELTA = '0;
`endif

endmodule

// File: tb/tb_f_key_quant.sv
// Directed bench for f_key_quant; DELTA expectations follow FKQ_DELTA_EN.
module tb_f_key_quant;
    import f_key_quant_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        OUT_READY = 1'b0;
    logic [23:0] F_IN = '0;
    logic        IN_READY, OUT_VALID, BELOW, ABOVE;
    logic [6:0]  KEY_OUT;
    logic [24:0] DELTA;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FKQ_DELTA_EN
    localparam bit DELTA_ON = 1'b1;
`else
    localparam bit DELTA_ON = 1'b0;
`endif

    f_key_quant dut (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .F_IN(F_IN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .KEY_OUT(KEY_OUT),
        .BELOW(BELOW), .ABOVE(ABOVE), .DELTA(DELTA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dexp(input int v);
        return DELTA_ON ? 32'(v) : 32'd0;
    endfunction

    function automatic logic [31:0] dsx();
        return 32'({{7{DELTA[24]}}, DELTA});
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns the cycle in which OUT_VALID is first seen, transfer cycle = 0.
    task automatic xfer(input logic [23:0] f, output int lat);
        int w;
        F_IN = f;
        IN_VALID = 1'b1;
        w = 0;
        while (!IN_READY && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_wait", 32'(IN_READY), 32'd1);
        tick();
        IN_VALID = 1'b0;
        lat = 1;
        while (!OUT_VALID && lat < 30) begin
            tick();
            lat++;
        end
        check("out_valid_wait", 32'(OUT_VALID), 32'd1);
    endtask

    task automatic accept();
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("out_valid_drop", 32'(OUT_VALID), 32'd0);
        check("in_ready_back", 32'(IN_READY), 32'd1);
    endtask

    task automatic run_vec(input string tag, input logic [23:0] f, input int key,
                           input int bl, input int ab, input int dl);
        int lat;
        xfer(f, lat);
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_key"}, 32'(KEY_OUT), 32'(key));
        check({tag, "_below"}, 32'(BELOW), 32'(bl));
        check({tag, "_above"}, 32'(ABOVE), 32'(ab));
        check({tag, "_delta"}, dsx(), dexp(dl));
        accept();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, first, second, ov_seen;

        repeat (3) tick();
        check("rst_in_ready", 32'(IN_READY), 32'd0);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_key", 32'(KEY_OUT), 32'd12);
        check("rst_below", 32'(BELOW), 32'd0);
        check("rst_above", 32'(ABOVE), 32'd0);
        check("rst_delta", dsx(), 32'd0);
        RESET_N = 1'b1;
        tick();
        check("idle_in_ready", 32'(IN_READY), 32'd1);

        run_vec("exact69", 24'h028DD5, 69, 0, 0, 0);
        run_vec("tie60", 24'h019054, 60, 0, 0, 2959);
        run_vec("past_tie61", 24'h019055, 61, 0, 0, -2958);
        run_vec("zero", 24'h000000, 12, 1, 0, -6220);
        run_vec("max", 24'hFFFFFF, 119, 0, 1, 13771154);
        run_vec("edge12", 24'h00184C, 12, 0, 0, 0);
        run_vec("edge119", 24'h2DDE6D, 119, 0, 0, 0);
        run_vec("near60", 24'd100000, 60, 0, 0, 475);

        // Stall: result must hold and a pending IN_VALID must not be taken.
        xfer(24'h019BE3, lat);
        IN_VALID = 1'b1;
        F_IN = 24'h000123;
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", 32'(OUT_VALID), 32'd1);
            check("stall_in_ready", 32'(IN_READY), 32'd0);
            check("stall_key", 32'(KEY_OUT), 32'd61);
            check("stall_below", 32'(BELOW), 32'd0);
            check("stall_delta", dsx(), dexp(0));
            tick();
        end
        IN_VALID = 1'b0;
        accept();
        run_vec("after_stall", 24'h2DDE6D, 119, 0, 0, 0);

        // Back-to-back transfers with OUT_READY held high.
        OUT_READY = 1'b1;
        IN_VALID = 1'b1;
        F_IN = 24'd100000;
        first = -1;
        second = -1;
        for (int c = 0; c < 30; c++) begin
            if (IN_READY) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            tick();
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        check("throughput", 32'(second - first), 32'd10);
        check("tp_key", 32'(KEY_OUT), 32'd60);
        check("tp_idle", 32'(IN_READY), 32'd1);

        // Reset during the fourth search cycle.
        F_IN = 24'hFFFFFF;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        repeat (3) tick();
        RESET_N = 1'b0;
        #1;
        check("abort_out_valid", 32'(OUT_VALID), 32'd0);
        check("abort_in_ready", 32'(IN_READY), 32'd0);
        check("abort_key", 32'(KEY_OUT), 32'd12);
        check("abort_above", 32'(ABOVE), 32'd0);
        check("abort_delta", dsx(), 32'd0);
        repeat (2) tick();
        RESET_N = 1'b1;
        ov_seen = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (OUT_VALID) ov_seen++;
        end
        check("abort_no_stale", 32'(ov_seen), 32'd0);
        run_vec("post_abort", 24'h0184C5, 60, 0, 0, 0);

        for (int k = KEY_MIN; k <= KEY_MAX; k++) begin
            run_vec("sweep", INCR[k - KEY_MIN], k, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
